// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader that fills the 16-bit instruction memory from a byte stream and serves core fetches
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds trailing 16-bit checksum check).
module imem_loader #(
    parameter int p_INST_NUM = 1024,
    parameter int p_ADDR_W   = 10
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    input  logic [15:0] i_pc,
    output logic [15:0] o_inst,
    output logic        o_core_rst,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_words_loaded
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM_HI,
        S_CSUM_LO,
`endif
        S_DONE,
        S_ERR
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CSUM_HI;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    // 17 bits so that p_INST_NUM == 65536 would still compare correctly
    localparam logic [16:0] INST_NUM_X = 17'(p_INST_NUM);

    state_t      state, state_nxt;
    logic [7:0]  hi_q;
    logic [15:0] len_q;
    logic [15:0] count_q;
    logic [15:0] word;
    logic [15:0] count_inc;
    logic        accept;
    logic        start_ok;
    logic [15:0] mem [p_INST_NUM];
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0] sum_q;
`endif

    assign word      = {hi_q, i_byte};
    assign count_inc = count_q + 16'd1;
    assign accept    = i_byte_valid & o_byte_ready;
    assign start_ok  = i_start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (i_start) state_nxt = S_LEN_HI;
            S_LEN_HI:  if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (word == 16'd0)
                        state_nxt = S_AFTER_DATA;
                    else if ({1'b0, word} > INST_NUM_X)
                        state_nxt = S_ERR;
                    else
                        state_nxt = S_DATA_HI;
                end
            end
            S_DATA_HI: if (accept) state_nxt = S_DATA_LO;
            S_DATA_LO: if (accept) state_nxt = (count_inc == len_q) ? S_AFTER_DATA : S_DATA_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM_HI: if (accept) state_nxt = S_CSUM_LO;
            S_CSUM_LO: if (accept) state_nxt = (word == sum_q) ? S_DONE : S_ERR;
`endif
            default:   state_nxt = S_IDLE;
        endcase
    end

    // All status outputs decode the registered state, so they change on the same edge as the state
    always_comb begin
        o_byte_ready = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_core_rst   = 1'b1;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM_HI, S_CSUM_LO: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
            end
`endif
            S_DONE: begin
                o_done     = 1'b1;
                o_core_rst = 1'b0;
            end
            S_ERR:   o_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_q    <= 8'd0;
            len_q   <= 16'd0;
            count_q <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= 16'd0;
`endif
        end else if (start_ok) begin
            count_q <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= 16'd0;
`endif
        end else if (accept) begin
            case (state)
                S_LEN_HI, S_DATA_HI: hi_q <= i_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM_HI: hi_q <= i_byte;
`endif
                S_LEN_LO: len_q <= word;
                S_DATA_LO: begin
                    count_q <= count_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_q   <= sum_q + word;
`endif
                end
                default: ;
            endcase
        end
    end

    // Memory contents deliberately survive reset
    always_ff @(posedge i_clk) begin
        if (accept && (state == S_DATA_LO))
            mem[count_q[p_ADDR_W-1:0]] <= word;
    end

    assign o_inst = (o_core_rst || ({1'b0, i_pc} >= INST_NUM_X)) ? 16'h0000
                                                                 : mem[i_pc[p_ADDR_W-1:0]];
    assign o_words_loaded = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader with a fetch-port scoreboard
module tb_imem_loader;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_byte = 8'd0;
    logic        i_byte_valid = 1'b0;
    logic [15:0] i_pc = 16'd0;
    logic        o_byte_ready;
    logic [15:0] o_inst;
    logic        o_core_rst;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [15:0] o_words_loaded;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic [15:0] wbuf[8];

    imem_loader #(.p_INST_NUM(1024), .p_ADDR_W(10)) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_start(i_start),
        .i_byte(i_byte),
        .i_byte_valid(i_byte_valid),
        .o_byte_ready(o_byte_ready),
        .i_pc(i_pc),
        .o_inst(o_inst),
        .o_core_rst(o_core_rst),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_err(o_err),
        .o_words_loaded(o_words_loaded)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte was taken
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(negedge i_clk);
        i_byte       = b;
        i_byte_valid = 1'b1;
        while (o_byte_ready !== 1'b1 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 20) check("ready_timeout", {31'd0, o_byte_ready}, 32'd1);
        @(negedge i_clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_byte_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Sends LEN, wbuf[0..n-1] and (when enabled) the matching checksum; expected words go to exp_q
    task automatic load(input int n, input int maxgap, input bit poke);
        logic [15:0] len;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [15:0] sum = 16'd0;
`endif
        len = 16'(n);
        send_byte(len[15:8], $urandom_range(0, maxgap));
        send_byte(len[7:0], $urandom_range(0, maxgap));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(wbuf[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum += wbuf[i];
`endif
            if (poke && i == 1) pulse_start();
            send_byte(wbuf[i][15:8], $urandom_range(0, maxgap));
            check("core_rst_held", {31'd0, o_core_rst}, 32'd1);
            send_byte(wbuf[i][7:0], $urandom_range(0, maxgap));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(sum[15:8], 0);
        send_byte(sum[7:0], 0);
`endif
    endtask

    task automatic verify_mem();
        logic [15:0] e;
        for (int i = 0; exp_q.size() > 0; i++) begin
            i_pc = 16'(i);
            e    = exp_q.pop_front();
            #1;
            check("mem_word", {16'd0, o_inst}, {16'd0, e});
        end
        @(negedge i_clk);
    endtask

    task automatic set_case1();
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'hABCD;
        wbuf[2] = 16'h0001;
    endtask

    initial begin
        @(negedge i_clk);
        do_reset();
        check("rst_core_rst", {31'd0, o_core_rst}, 32'd1);
        check("rst_ready", {31'd0, o_byte_ready}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_words", {16'd0, o_words_loaded}, 32'd0);

        // Case 1: three words, core released after the last byte
        set_case1();
        pulse_start();
        check("c1_busy", {31'd0, o_busy}, 32'd1);
        check("c1_ready", {31'd0, o_byte_ready}, 32'd1);
        load(3, 0, 1'b0);
        check("c1_done", {31'd0, o_done}, 32'd1);
        check("c1_core_rst", {31'd0, o_core_rst}, 32'd0);
        check("c1_busy_end", {31'd0, o_busy}, 32'd0);
        check("c1_words", {16'd0, o_words_loaded}, 32'd3);
        check("c1_ready_end", {31'd0, o_byte_ready}, 32'd0);
        verify_mem();
        i_pc = 16'd1024;
        #1 check("c1_pc_oob", {16'd0, o_inst}, 32'd0);
        @(negedge i_clk);

        // Case 2: empty load
        pulse_start();
        check("c2_done_clr", {31'd0, o_done}, 32'd0);
        load(0, 0, 1'b0);
        check("c2_done", {31'd0, o_done}, 32'd1);
        check("c2_words", {16'd0, o_words_loaded}, 32'd0);
        i_pc = 16'd0;
        #1 check("c2_no_write", {16'd0, o_inst}, 32'h1234);
        @(negedge i_clk);

        // Case 3: oversize length
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        check("c3_err", {31'd0, o_err}, 32'd1);
        check("c3_ready", {31'd0, o_byte_ready}, 32'd0);
        check("c3_core_rst", {31'd0, o_core_rst}, 32'd1);
        check("c3_words", {16'd0, o_words_loaded}, 32'd0);
        i_pc = 16'd1;
        #1 check("c3_nop_in_rst", {16'd0, o_inst}, 32'd0);
        @(negedge i_clk);
        pulse_start();
        load(0, 0, 1'b0);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'hABCD);
        exp_q.push_back(16'h0001);
        verify_mem();

        // Case 5: reset in the middle of a load, then reload
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        check("c5_words_mid", {16'd0, o_words_loaded}, 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check("c5_core_rst", {31'd0, o_core_rst}, 32'd1);
        check("c5_words", {16'd0, o_words_loaded}, 32'd0);
        check("c5_busy", {31'd0, o_busy}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        pulse_start();
        load(3, 0, 1'b0);
        check("c5_done", {31'd0, o_done}, 32'd1);
        check("c5_words_end", {16'd0, o_words_loaded}, 32'd3);
        verify_mem();

        // Case 4: valid in IDLE ignored, gapped stream, start while busy ignored
        do_reset();
        i_byte       = 8'hEE;
        i_byte_valid = 1'b1;
        repeat (5) @(negedge i_clk);
        check("c4_idle_ready", {31'd0, o_byte_ready}, 32'd0);
        i_byte_valid = 1'b0;
        for (int i = 0; i < 4; i++) wbuf[i] = 16'($urandom);
        pulse_start();
        load(4, 3, 1'b1);
        check("c4_done", {31'd0, o_done}, 32'd1);
        check("c4_words", {16'd0, o_words_loaded}, 32'd4);
        verify_mem();

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Case 6: checksum mismatch (good checksum BE02 was exercised by the loads above)
        set_case1();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        for (int i = 0; i < 3; i++) begin
            send_byte(wbuf[i][15:8], 0);
            send_byte(wbuf[i][7:0], 0);
        end
        send_byte(8'hBE, 0);
        send_byte(8'h03, 0);
        check("c6_err", {31'd0, o_err}, 32'd1);
        check("c6_core_rst", {31'd0, o_core_rst}, 32'd1);
        check("c6_done", {31'd0, o_done}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
